// File: rtl/call_stack_pkg.sv
// Shared defaults and the pointer-width helper for the return-address stack.
package call_stack_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_DEPTH      = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: synchronous write port, combinational read of the top entry (sp-1).
module call_stack_mem
    import call_stack_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int Depth     = DEFAULT_DEPTH,
    parameter int PtrWidth  = ptr_width(Depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PtrWidth-1:0]  waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [PtrWidth-1:0]  sp,
    output logic [DataWidth-1:0] rdata
);

    localparam logic [PtrWidth-1:0] PTR_ONE = 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  top_addr;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign top_addr = sp - PTR_ONE;
    assign rdata    = mem_q[top_addr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack for nested subroutine calls.
// CALL_STACK_ERR_EN: full push is dropped and sticky Overflow/Underflow flags are kept;
// otherwise full push overwrites the oldest entry circularly and the flags read 0.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int Depth     = DEFAULT_DEPTH,
    parameter int PtrWidth  = ptr_width(Depth)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Push,
    input  logic                 Pop,
    input  logic                 Flush,
    input  logic [DataWidth-1:0] DIn,
    output logic [DataWidth-1:0] DOut,
    output logic [PtrWidth:0]    Count,
    output logic                 Empty,
    output logic                 Full,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam logic [PtrWidth:0]   FULL_CNT = (PtrWidth+1)'(Depth);
    localparam logic [PtrWidth:0]   CNT_ONE  = 1;
    localparam logic [PtrWidth-1:0] PTR_ONE  = 1;

    logic [PtrWidth-1:0]  sp_q, sp_d;
    logic [PtrWidth:0]    count_q, count_d;
    logic                 we;
    logic [PtrWidth-1:0]  waddr;
    logic [DataWidth-1:0] rd_data;

`ifdef CALL_STACK_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
`endif

    assign Empty = (count_q == '0);
    assign Full  = (count_q == FULL_CNT);
    assign Count = count_q;
    assign DOut  = Empty ? '0 : rd_data;

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = sp_q;
`ifdef CALL_STACK_ERR_EN
        ovf_d   = ovf_q;
        unf_d   = unf_q;
`endif
        if (Flush) begin
            sp_d    = '0;
            count_d = '0;
        end else if (Push && Pop && !Empty) begin
            // Return-then-call: replace the top in place, legal even when full.
            we    = 1'b1;
            waddr = sp_q - PTR_ONE;
        end else if (Push) begin
            if (!Full) begin
                we      = 1'b1;
                sp_d    = sp_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end else begin
`ifdef CALL_STACK_ERR_EN
                ovf_d = 1'b1;
`else
                we   = 1'b1;
                sp_d = sp_q + PTR_ONE;
`endif
            end
        end else if (Pop) begin
            if (!Empty) begin
                sp_d    = sp_q - PTR_ONE;
                count_d = count_q - CNT_ONE;
            end else begin
`ifdef CALL_STACK_ERR_EN
                unf_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sp_q    <= '0;
            count_q <= '0;
`ifdef CALL_STACK_ERR_EN
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`endif
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
`ifdef CALL_STACK_ERR_EN
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`endif
        end
    end

`ifdef CALL_STACK_ERR_EN
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

    call_stack_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .PtrWidth  (PtrWidth)
    ) u_mem (
        .clk   (Clk),
        .we    (we && !Reset),
        .waddr (waddr),
        .wdata (DIn),
        .sp    (sp_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_call_stack.sv
// Directed scoreboard bench for call_stack at Depth=4, DataWidth=16 (both CALL_STACK_ERR_EN builds).
module tb_call_stack;

    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int PW = 2;
`ifdef CALL_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset, Push, Pop, Flush;
    logic [DW-1:0] DIn;
    logic [DW-1:0] DOut;
    logic [PW:0]   Count;
    logic          Empty, Full, Overflow, Underflow;

    call_stack #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Push      (Push),
        .Pop       (Pop),
        .Flush     (Flush),
        .DIn       (DIn),
        .DOut      (DOut),
        .Count     (Count),
        .Empty     (Empty),
        .Full      (Full),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] dout;
        logic [PW:0]   cnt;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic ovf_e = 1'b0;
    logic unf_e = 1'b0;

    task automatic check_top();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (DOut === e.dout) else begin
            failures++;
            $error("FAIL %s dout got=%h want=%h", e.tag, DOut, e.dout);
        end
        checks++;
        assert (Count === e.cnt) else begin
            failures++;
            $error("FAIL %s count got=%0d want=%0d", e.tag, Count, e.cnt);
        end
        checks++;
        assert ({Empty, Full} === {e.empty, e.full}) else begin
            failures++;
            $error("FAIL %s empty/full got=%b%b want=%b%b", e.tag, Empty, Full, e.empty, e.full);
        end
        checks++;
        assert ({Overflow, Underflow} === {e.ovf, e.unf}) else begin
            failures++;
            $error("FAIL %s ovf/unf got=%b%b want=%b%b", e.tag, Overflow, Underflow, e.ovf, e.unf);
        end
    endtask

    // Drive one cycle of strobes, queue the expected post-edge state, then compare.
    task automatic op(input string tag, input logic rst, input logic fl, input logic pu,
                      input logic po, input logic [DW-1:0] d,
                      input logic [DW-1:0] edout, input int ecnt);
        exp_t e;
        Reset = rst; Flush = fl; Push = pu; Pop = po; DIn = d;
        e.tag = tag; e.dout = edout; e.cnt = ecnt[PW:0];
        e.empty = (ecnt == 0); e.full = (ecnt == DEPTH);
        e.ovf = ovf_e; e.unf = unf_e;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Reset = 1'b0; Flush = 1'b0; Push = 1'b0; Pop = 1'b0;
        check_top();
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; Push = 1'b0; Pop = 1'b0; DIn = '0;
        @(posedge Clk);
        op("reset", 1, 0, 0, 0, 16'h0000, 16'h0000, 0);

        op("push11", 0, 0, 1, 0, 16'h0011, 16'h0011, 1);
        op("push22", 0, 0, 1, 0, 16'h0022, 16'h0022, 2);
        op("push33", 0, 0, 1, 0, 16'h0033, 16'h0033, 3);
        op("pop1",   0, 0, 0, 1, 16'h0000, 16'h0022, 2);
        op("pop2",   0, 0, 0, 1, 16'h0000, 16'h0011, 1);
        op("pop3",   0, 0, 0, 1, 16'h0000, 16'h0000, 0);

        op("fillA", 0, 0, 1, 0, 16'h000A, 16'h000A, 1);
        op("fillB", 0, 0, 1, 0, 16'h000B, 16'h000B, 2);
        op("fillC", 0, 0, 1, 0, 16'h000C, 16'h000C, 3);
        op("fillD", 0, 0, 1, 0, 16'h000D, 16'h000D, 4);
        ovf_e = ERR;
        if (ERR) begin
            op("ovf_push", 0, 0, 1, 0, 16'h000E, 16'h000D, 4);
            op("opop1", 0, 0, 0, 1, 16'h0000, 16'h000C, 3);
            op("opop2", 0, 0, 0, 1, 16'h0000, 16'h000B, 2);
            op("opop3", 0, 0, 0, 1, 16'h0000, 16'h000A, 1);
            op("opop4", 0, 0, 0, 1, 16'h0000, 16'h0000, 0);
        end else begin
            op("wrap_push", 0, 0, 1, 0, 16'h000E, 16'h000E, 4);
            op("wpop1", 0, 0, 0, 1, 16'h0000, 16'h000D, 3);
            op("wpop2", 0, 0, 0, 1, 16'h0000, 16'h000C, 2);
            op("wpop3", 0, 0, 0, 1, 16'h0000, 16'h000B, 1);
            op("wpop4", 0, 0, 0, 1, 16'h0000, 16'h0000, 0);
        end

        unf_e = ERR;
        op("pop_empty", 0, 0, 0, 1, 16'h0000, 16'h0000, 0);

        op("push100", 0, 0, 1, 0, 16'h0100, 16'h0100, 1);
        op("push200", 0, 0, 1, 0, 16'h0200, 16'h0200, 2);
        op("replace", 0, 0, 1, 1, 16'h0300, 16'h0300, 2);
        op("pop_rep", 0, 0, 0, 1, 16'h0000, 16'h0100, 1);
        op("push400", 0, 0, 1, 0, 16'h0400, 16'h0400, 2);
        op("push500", 0, 0, 1, 0, 16'h0500, 16'h0500, 3);
        op("flush_push", 0, 1, 1, 0, 16'h0600, 16'h0000, 0);

        ovf_e = 1'b0; unf_e = 1'b0;
        op("reset_flags", 1, 0, 0, 0, 16'h0000, 16'h0000, 0);

        op("pp_empty", 0, 0, 1, 1, 16'h0077, 16'h0077, 1);
        op("fill2", 0, 0, 1, 0, 16'h0078, 16'h0078, 2);
        op("fill3", 0, 0, 1, 0, 16'h0079, 16'h0079, 3);
        op("fill4", 0, 0, 1, 0, 16'h007A, 16'h007A, 4);
        op("pp_full", 0, 0, 1, 1, 16'h007B, 16'h007B, 4);
        op("pop_full", 0, 0, 0, 1, 16'h0000, 16'h0079, 3);

        op("reset_push", 1, 0, 1, 0, 16'h00EE, 16'h0000, 0);
        op("push55", 0, 0, 1, 0, 16'h0055, 16'h0055, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_stack.md
# call_stack

- Parametrised hardware return-address stack for the A09 core family.
- Replaces the single-entry `Stack` register, so subroutine calls can nest up to `Depth` levels.
- Sits between the PC output (push data) and the PC source mux (return address).
- Driven by single-cycle push/pop strobes from the sequence control matrix; reports occupancy and error status back to it.

## Interface
- `DataWidth`, 16, width of each stored return address.
- `Depth`, 8, number of entries; must be a power of two, ≥ 2.
- `PtrWidth`, `$clog2(Depth)`, derived; not overridden by instantiators.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high; clears pointer, count and flags.
- `Push`  in  1  store `DIn` as the new top this cycle.
- `Pop`  in  1  discard the current top this cycle.
- `Flush`  in  1  empty the stack (exception/restart path).
- `DIn`  in  DataWidth  return address to push (PC value).
- `DOut`  out  DataWidth  current top entry; 0 when empty.
- `Count`  out  PtrWidth+1  number of valid entries, 0..Depth.
- `Empty`  out  1  `Count == 0`.
- `Full`  out  1  `Count == Depth`.
- `Overflow`  out  1  sticky; push attempted while full (see Configuration).
- `Underflow`  out  1  sticky; pop attempted while empty (see Configuration).

## Operation
- Storage is `Depth` × `DataWidth`, unreset. State is the write pointer `sp` (PtrWidth, wraps mod `Depth`), `Count`, and the two sticky flags.
- Top is `mem[sp-1]` (mod `Depth`). `DOut` is combinational from the top entry, gated to 0 when `Count == 0`.
- Priority per edge: `Reset` > `Flush` > {`Push`, `Pop`}.
- `Reset`: `sp = 0`, `Count = 0`, `Overflow = 0`, `Underflow = 0`.
- `Flush`: `sp = 0`, `Count = 0`; sticky flags unchanged; `Push`/`Pop` ignored that cycle.
- Push only, not full: `mem[sp] = DIn`, `sp+1`, `Count+1`.
- Push only, full: behaviour set by the macro (see Configuration).
- Pop only, not empty: `sp-1`, `Count-1`. The popped value is `DOut` during the pop cycle.
- Pop only, empty: no state change except the flag (see Configuration).
- Push+Pop, not empty: replace the top (`mem[sp-1] = DIn`); `sp` and `Count` unchanged. This is legal when full and sets no flag.
- Push+Pop, empty: treated as push only; no Underflow.
- All arithmetic is modulo `Depth` on `sp`. `Count` saturates at `Depth` and never goes below 0.

## Timing
- Read latency is 0: `DOut`, `Empty`, `Full` and `Count` reflect state after the most recent edge.
- Write latency is 1: a value pushed at edge N appears on `DOut` after edge N.
- Every strobe is single-cycle with no handshake; a new operation is accepted every cycle.
- Reset values: `DOut = 0`, `Count = 0`, `Empty = 1`, `Full = 0`, `Overflow = 0`, `Underflow = 0`.
- `Reset` asserted mid-sequence discards all entries on that edge; stale memory is never visible because `DOut` is gated by `Count`.

## Configuration
- Macro: `CALL_STACK_ERR_EN`.
- Defined:
  - Push only while full is ignored (no write, no pointer move) and sets `Overflow`.
  - Pop only while empty sets `Underflow`.
  - Both flags hold until `Reset`.
- Undefined:
  - Push while full overwrites the oldest entry circularly: `mem[sp] = DIn`, `sp+1`, `Count` stays at `Depth`. Deep recursion therefore keeps the newest `Depth` returns.
  - `Overflow` and `Underflow` are tied to 0.

## Structure
- Shared package/constants file holds the default `DataWidth` and `Depth`, plus a localparam helper for `PtrWidth`.
- One sub-module: `call_stack_mem`, the storage array with a synchronous write port and a combinational read port at `sp-1`.
- Pointer, count, flag logic and priority decoding live in `call_stack`.

## Test plan
All scenarios use `Depth = 4`, `DataWidth = 16`.
- Reset, then push `0x0011`, `0x0022`, `0x0033` → `Count = 3`, `DOut = 0x0033`; three pops give `DOut` `0x0033`, `0x0022`, `0x0011`, then `Empty = 1`, `DOut = 0`.
- Push 4 values `0x0A`..`0x0D`, then push `0x0E`:
  - `ERR_EN` defined → `Full = 1`, `DOut = 0x0D`, `Overflow = 1`.
  - Undefined → `DOut = 0x0E`, `Count = 4`; four pops give `0x0E`, `0x0D`, `0x0C`, `0x0B`.
- Pop on empty → `Count` stays 0; `Underflow = 1` with `ERR_EN` defined, 0 without.
- Stack holds `0x0100`, `0x0200`; assert Push+Pop with `DIn = 0x0300` → `Count = 2`, `DOut = 0x0300`; one pop gives `DOut = 0x0100`.
- `Flush` and `Push` together with 3 entries present → `Count = 0`, `DOut = 0`, flags unchanged; `Reset` then clears a set `Overflow`.
- `Reset` asserted in the same cycle as `Push` → `Count = 0`, `Empty = 1`; the next push of `0x0055` gives `DOut = 0x0055`, `Count = 1`.
